// File: rtl/seq_shift_pkg.sv
// Shared types for the sequential shift/rotate engine.
// Latency: none (types only).
// Backpressure: n/a.
package seq_shift_pkg;

    // Operation select, encoded to match the in_mode port.
    typedef enum logic [1:0] {
        SM_SLL = 2'b00,
        SM_SRL = 2'b01,
        SM_SRA = 2'b10,
        SM_ROR = 2'b11
    } shift_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } shift_state_e;

endpackage

// File: rtl/seq_shift_unit_shift_step.sv
// One iteration of the shift engine: shifts a word by s (0..STEP) bits in a given mode.
// Latency: combinational.
// Backpressure: n/a.
//
// Ports:
//   word_i  - word to shift
//   s_i     - shift distance for this step, 0..STEP
//   mode_i  - SLL / SRL / SRA / ROR
//   sign_i  - fill bit for SRA (original operand MSB)
//   word_o  - shifted word
module shift_step
    import seq_shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    localparam int SW   = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] word_i,
    input  logic [SW-1:0]    s_i,
    input  shift_mode_e      mode_i,
    input  logic             sign_i,
    output logic [WIDTH-1:0] word_o
);

    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    logic [WIDTH-1:0] srl_w;
    logic [WIDTH-1:0] fill_mask;

    always_comb begin
        srl_w     = word_i >> s_i;
        // Ones in the top s bits: the positions vacated by a right shift.
        fill_mask = ~(ONES >> s_i);
        word_o    = word_i;
        case (mode_i)
            SM_SLL:  word_o = word_i << s_i;
            SM_SRL:  word_o = srl_w;
            SM_SRA:  word_o = srl_w | (fill_mask & {WIDTH{sign_i}});
            // A shift by WIDTH yields zero, so s=0 degenerates cleanly to word_i.
            SM_ROR:  word_o = srl_w | (word_i << (WIDTH - int'(s_i)));
            default: word_o = word_i;
        endcase
    end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate engine: shifts by up to STEP bits per clock, then holds the result.
// Latency: ceil(amt/STEP) clocks from accept to out_valid (0 extra for amt=0).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, no queueing.
//
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   in_valid/in_ready     - request handshake; in_data, in_amt, in_mode sampled on accept
//   out_valid/out_ready   - result handshake; out_data stable while out_valid
//   busy                  - operation in flight (SHIFT or DONE)
module seq_shift_unit
    import seq_shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AW-1:0]    in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int SW  = $clog2(STEP + 1);
    localparam int AWX = AW + 1;
    // STEP may equal WIDTH, which does not fit in AW bits; compare one bit wider.
    localparam logic [AWX-1:0] STEP_X = AWX'(STEP);

    shift_state_e     state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [AW-1:0]    rem_q,   rem_d;
    shift_mode_e      mode_q,  mode_d;
    logic             sign_q,  sign_d;

    logic [AWX-1:0]   rem_x;
    logic [AWX-1:0]   s_x;
    logic             last_step;
    logic [WIDTH-1:0] step_word;

    // Step size for this clock: min(STEP, remaining).
    always_comb begin
        rem_x     = {1'b0, rem_q};
        last_step = (rem_x <= STEP_X);
        s_x       = last_step ? rem_x : STEP_X;
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .word_i (data_q),
        .s_i    (SW'(s_x)),
        .mode_i (mode_q),
        .sign_i (sign_q),
        .word_o (step_word)
    );

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = (in_amt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last_step) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        busy      = (state_q != ST_IDLE);
    end

    // Datapath next state: load on accept, step while shifting, hold otherwise.
    always_comb begin
        data_d = data_q;
        rem_d  = rem_q;
        mode_d = mode_q;
        sign_d = sign_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d = in_data;
                    rem_d  = in_amt;
                    mode_d = shift_mode_e'(in_mode);
                    sign_d = in_data[WIDTH-1];
                end
            end
            ST_SHIFT: begin
                data_d = step_word;
                rem_d  = AW'(rem_x - s_x);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            rem_q  <= '0;
            mode_q <= SM_SLL;
            sign_q <= 1'b0;
        end else begin
            data_q <= data_d;
            rem_q  <= rem_d;
            mode_q <= mode_d;
            sign_q <= sign_d;
        end
    end

    assign out_data = data_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Scoreboard bench for seq_shift_unit (WIDTH=32, STEP=4).
// Driver pushes expected results and first-valid cycle; monitor pops on out_valid.
// Consumer out_ready is randomised except where a stall is forced.
module tb_seq_shift_unit;

    localparam int WIDTH = 32;
    localparam int STEP  = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [4:0]       in_amt;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    seq_shift_unit #(.WIDTH(WIDTH), .STEP(STEP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    typedef struct {
        logic [WIDTH-1:0] data;
        int               cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc          = 0;
    int   nvec         = 0;
    int   nerr         = 0;
    int   drv_timeouts = 0;
    bit   drv_done     = 1'b0;
    bit   hold_low     = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer: mostly ready, occasionally stalls, forced low on request.
    always @(posedge clk) begin
        #1;
        out_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Reference: the single-cycle operation by amt.
    function automatic logic [WIDTH-1:0] ref_op(input logic [WIDTH-1:0] x, input int amt,
                                                input logic [1:0] m);
        case (m)
            2'd0:    return x << amt;
            2'd1:    return x >> amt;
            2'd2:    return $unsigned($signed(x) >>> amt);
            default: return (x >> amt) | (x << ((WIDTH - amt) % WIDTH));
        endcase
    endfunction

    // Called at posedge+1; returns at posedge+1.
    task automatic wait_idle();
        int waited = 0;
        while (!in_ready && waited < 300) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) drv_timeouts++;
    endtask

    task automatic issue(input logic [WIDTH-1:0] d, input int amt, input logic [1:0] m);
        wait_idle();
        if (!in_ready) return;
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = 5'(amt);
        in_mode  = m;
        @(posedge clk); #1;
        exp_q.push_back('{ref_op(d, amt, m), cyc + (amt + STEP - 1) / STEP});
        // Scramble inputs after acceptance; they must have no effect.
        in_valid = 1'b0;
        in_data  = $urandom;
        in_amt   = 5'($urandom);
        in_mode  = 2'($urandom);
    endtask

    // Driver
    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'hF000000F;
        in_amt   = 5'd4;
        in_mode  = 2'd1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(32'hF000000F, 4, 2'd1);
        issue(32'hF0000000, 7, 2'd2);
        issue(32'h0000000F, 7, 2'd0);
        issue(32'h0000000F, 31, 2'd0);
        issue(32'h0000000F, 4, 2'd3);

        // amt=0 with the consumer stalled; extra requests must be ignored.
        wait_idle();
        hold_low = 1'b1;
        issue(32'hA5A5A5A5, 0, 2'($urandom_range(0, 3)));
        repeat (5) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            in_amt   = 5'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        hold_low = 1'b0;

        // Reset during the third shift cycle of a 5-step operation.
        issue(32'h89ABCDEF, 20, 2'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2;
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(32'h80000001, 20, 2'd2);
        issue(32'h12345678, 13, 2'd3);

        for (int i = 0; i < 100; i++) begin
            issue($urandom, int'($urandom_range(0, WIDTH - 1)), 2'($urandom_range(0, 3)));
        end
        wait_idle();
        drv_done = 1'b1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor
    initial begin
        exp_t cur;
        bit   prev_v = 1'b0;
        cur = '{'0, 0};
        while (!drv_done) begin
            @(negedge clk);
            if (!rst_n) begin
                chk("reset_values", {in_ready, out_valid, busy, out_data},
                    {1'b1, 1'b0, 1'b0, 32'h0});
                prev_v = 1'b0;
            end else begin
                if (out_valid) begin
                    if (!prev_v) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_output", 64'(out_valid), 64'd0);
                        end else begin
                            cur = exp_q.pop_front();
                            chk("first_valid_cycle", 64'(cur.cyc), 64'(cyc));
                            chk("result", 64'(out_data), 64'(cur.data));
                        end
                    end else begin
                        chk("held_result", 64'(out_data), 64'(cur.data));
                    end
                    chk("done_status", {in_ready, busy}, {1'b0, 1'b1});
                end
                prev_v = out_valid && !out_ready;
            end
        end
        chk("driver_timeouts", 64'(drv_timeouts), 64'd0);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
